// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the keypad scanner
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam logic [KP_ROWS-1:0] KP_IDLE_ROWS = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    // Active-low column drive: only the indexed column is pulled low.
    function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Index of the lowest-numbered low row; row 0 wins on a multi-row press.
    function automatic logic [1:0] lowest_low_row(input logic [KP_ROWS-1:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous board inputs
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_async    : asynchronous input bus
//   o_sync     : synchronized copy, resets to all ones (idle for pulled-up pins)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with debounce
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   row_in     : keypad rows, active-low, asynchronous
//   col_out    : column drive, active-low, exactly one bit low
//   key_code   : {row_idx, col_idx} of the last accepted key
//   key_valid  : one-cycle strobe on an accepted press
//   key_held   : high while the accepted key is still held
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

    logic [KP_ROWS-1:0] w_row_s;
    logic               w_rows_idle;

    kp_state_e          r_state;
    logic [1:0]         r_col_idx;
    logic [DIV_W-1:0]   r_div;
    logic [DB_W-1:0]    r_db_cnt;
    logic [KP_ROWS-1:0] r_row_pat;
    logic [1:0]         r_row_idx;
    logic [KP_COLS-1:0] r_col_out;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_held;

    sync_2ff #(
        .WIDTH (KP_ROWS)
    ) u_row_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (row_in),
        .o_sync  (w_row_s)
    );

    assign w_rows_idle = (w_row_s == KP_IDLE_ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_div       <= '0;
            r_db_cnt    <= '0;
            r_row_pat   <= KP_IDLE_ROWS;
            r_row_idx   <= 2'd0;
            r_col_out   <= 4'b1110;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    // Rows are only judged on the last cycle of a slot so the
                    // synchronizer has settled on the newly driven column.
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (w_rows_idle) begin
                            r_col_idx <= r_col_idx + 2'd1;
                            r_col_out <= col_drive(r_col_idx + 2'd1);
                        end else begin
                            r_row_pat <= w_row_s;
                            r_row_idx <= lowest_low_row(w_row_s);
                            r_db_cnt  <= '0;
                            r_state   <= DEBOUNCE;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (w_row_s != r_row_pat) begin
                        r_div   <= '0;
                        r_state <= SCAN;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= {r_row_idx, r_col_idx};
                        r_key_held  <= 1'b1;
                        r_state     <= PRESSED;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    // Pattern changes while any row stays low are ignored.
                    if (w_rows_idle) begin
                        r_db_cnt <= '0;
                        r_state  <= REL_DB;
                    end
                end

                REL_DB: begin
                    if (!w_rows_idle) begin
                        r_state <= PRESSED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_key_held <= 1'b0;
                        r_div      <= '0;
                        r_col_idx  <= r_col_idx + 2'd1;
                        r_col_out  <= col_drive(r_col_idx + 2'd1);
                        r_state    <= SCAN;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end

                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_out   = r_col_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard testbench for keypad_scanner
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    // keys[r*4+c] set means the switch at row r, column c is closed.
    logic [15:0] keys;

    int          checks;
    int          failures;
    int          n_pushed;
    int          n_strobes;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a closed switch joins it to a
    // column that is currently driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] key_mask(input logic [3:0] rows, input int col);
        logic [15:0] m;
        m = '0;
        for (int r = 0; r < 4; r++) if (rows[r]) m[r*4+col] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] expected_code(input logic [3:0] rows, input int col);
        int lo;
        lo = 3;
        for (int r = 3; r >= 0; r--) if (rows[r]) lo = r;
        return 4'(lo * 4 + col);
    endfunction

    task automatic expect_key(input logic [3:0] code);
        exp_q.push_back(code);
        n_pushed++;
    endtask

    task automatic wait_held(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, key_held, level);
    endtask

    // Release everything; two sync cycles, one cycle to leave PRESSED, then
    // DC idle cycles in release debounce before key_held drops.
    task automatic release_and_check(input string name);
        keys = '0;
        repeat (DC + 2) @(negedge clk);
        check({name, "_held_before"}, key_held, 1'b1);
        @(negedge clk);
        check({name, "_held_after"}, key_held, 1'b0);
    endtask

    always @(negedge clk) begin
        check("col_onehot", $countones(~col_out), 1);
        if (key_valid === 1'b1) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%0h required=none", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code", key_code, mon_exp);
                check("held_at_strobe", key_held, 1'b1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] rows;
        logic [3:0] code;
        int         col;

        checks    = 0;
        failures  = 0;
        n_pushed  = 0;
        n_strobes = 0;
        keys      = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-scan, then check column stepping from a clean start.
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            check("scan_col_out", col_out, ~(32'd1 << ((k / SD) % 4)) & 32'hF);
            @(negedge clk);
        end

        // Single press: row 2 on column 1.
        keys[9] = 1'b1;
        expect_key(4'h9);
        repeat (40) @(negedge clk);
        check("single_held", key_held, 1'b1);
        release_and_check("single");
        check("single_code_kept", key_code, 4'h9);

        // Bounce on row 0 / column 3 never reaches the debounce length.
        for (int i = 0; i < 30; i++) begin
            keys[3] = ~keys[3];
            repeat (3) @(negedge clk);
            check("bounce_no_held", key_held, 1'b0);
        end
        keys = '0;
        repeat (30) @(negedge clk);

        // Release bounce on key 5.
        keys[5] = 1'b1;
        expect_key(4'h5);
        wait_held(1'b1, 200, "relb_accept");
        keys = '0;
        repeat (5) begin
            @(negedge clk);
            check("relb_glitch_held", key_held, 1'b1);
        end
        keys[5] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("relb_glitch_held", key_held, 1'b1);
        end
        release_and_check("relb");

        // Multi-row: rows 1 and 3 on column 0, row 1 wins.
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        expect_key(4'h4);
        wait_held(1'b1, 200, "multi_accept");
        repeat (10) @(negedge clk);
        release_and_check("multi");

        // Reset while PRESSED with the key still down.
        keys[14] = 1'b1;
        expect_key(4'hE);
        wait_held(1'b1, 200, "rstp_accept");
        repeat (5) @(negedge clk);
        expect_key(4'hE);
        rst_n = 1'b0;
        #1;
        check("rstp_col_out", col_out, 4'b1110);
        check("rstp_key_held", key_held, 1'b0);
        check("rstp_key_valid", key_valid, 1'b0);
        check("rstp_key_code", key_code, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DC) begin
            check("rstp_no_early_strobe", key_valid, 1'b0);
            @(negedge clk);
        end
        wait_held(1'b1, 200, "rstp_reaccept");
        release_and_check("rstp");

        // Randomized presses with optional short bounces and in-press changes.
        for (int it = 0; it < 24; it++) begin
            col  = $urandom_range(3);
            rows = 4'($urandom_range(15, 1));
            repeat ($urandom_range(3)) begin
                keys = key_mask(rows, col);
                repeat ($urandom_range(6, 1)) @(negedge clk);
                keys = '0;
                repeat ($urandom_range(6, 1)) @(negedge clk);
            end
            code = expected_code(rows, col);
            keys = key_mask(rows, col);
            expect_key(code);
            wait_held(1'b1, 200, "rand_accept");
            repeat ($urandom_range(15)) begin
                if ($urandom_range(3) == 0) keys = keys | key_mask(4'($urandom_range(15)), col);
                @(negedge clk);
            end
            release_and_check("rand");
            check("rand_code_kept", key_code, code);
            repeat ($urandom_range(8)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("strobe_count", n_strobes, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
